// File: rtl/mem_region_decoder.sv
// Address-range region decoder with read-only fault detection and first-fault capture.
// Optional MEM_REGION_FAULT_COUNT_EN adds a saturating 8-bit fault_count output.
module mem_region_decoder #(
  parameter int ADDR_W = 12,
  parameter int NREG = 3,
  parameter logic [NREG*ADDR_W-1:0] LIMITS = {12'hFFF, 12'h44B, 12'h400},
  parameter logic [NREG-1:0] RO_MASK = 3'b001,
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              MEMLOAD,
  input  logic              fault_clr,
  output logic [SEL_W-1:0]  sel,
  output logic [NREG-1:0]   load,
  output logic              acc_valid,
  output logic              fault,
`ifdef MEM_REGION_FAULT_COUNT_EN
  output logic [7:0]        fault_count,
`endif
  output logic [ADDR_W-1:0] fault_addr
);

  logic              w_hit;
  logic              w_ro;
  logic [SEL_W-1:0]  w_idx;
  logic              w_fault;
  logic              w_wr_ok;
  logic [NREG-1:0]   w_onehot;

  logic [SEL_W-1:0]  r_sel;
  logic [NREG-1:0]   r_load;
  logic              r_acc;
  logic              r_fault;
  logic [ADDR_W-1:0] r_fa;

  // Lowest region whose (previous limit, own limit] window holds addr.
  always_comb begin
    w_hit = 1'b0;
    w_ro  = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!w_hit
          && addr <= LIMITS[i*ADDR_W +: ADDR_W]
          && (i == 0
              || addr > LIMITS[((i > 0) ? i - 1 : 0)*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_ro  = RO_MASK[i];
        w_idx = SEL_W'(i);
      end
    end
  end

  assign w_fault  = req && (!w_hit || (MEMLOAD && w_ro));
  assign w_wr_ok  = req && MEMLOAD && !w_fault;
  assign w_onehot = NREG'(1) << w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_load  <= '0;
      r_acc   <= 1'b0;
      r_fault <= 1'b0;
      r_fa    <= '0;
    end else begin
      r_acc   <= req;
      r_load  <= w_wr_ok ? w_onehot : '0;
      if (req && w_hit)
        r_sel <= w_idx;
      r_fault <= w_fault | (r_fault & ~fault_clr);
      // A new fault wins over a concurrent clear.
      if (w_fault && (!r_fault || fault_clr))
        r_fa <= addr;
      else if (fault_clr)
        r_fa <= '0;
    end
  end

`ifdef MEM_REGION_FAULT_COUNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (fault_clr)
      r_cnt <= w_fault ? 8'd1 : 8'd0;
    else if (w_fault && r_cnt != 8'hFF)
      r_cnt <= r_cnt + 8'd1;
  end

  assign fault_count = r_cnt;
`endif

  assign sel        = r_sel;
  assign load       = r_load;
  assign acc_valid  = r_acc;
  assign fault      = r_fault;
  assign fault_addr = r_fa;

endmodule
